// File: rtl/sdram_cmd_scheduler.sv
// Shares the SDRAM command/address/bank pins between the read and write engines,
// arbitrates their requests round-robin and sequences periodic PRECHARGE-all + AUTO REFRESH.
module sdram_cmd_scheduler #(
  parameter int REFRESH_INTERVAL = 1560,
  parameter int T_RP             = 2,
  parameter int T_RFC            = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_req,
  input  logic        write_req,
  output logic        read_enable,
  output logic        write_enable,
  input  logic        read_idle,
  input  logic        write_idle,
  output logic        auto_refresh,
  input  logic [2:0]  read_command,
  input  logic [11:0] read_address,
  input  logic [1:0]  read_bank,
  input  logic [2:0]  write_command,
  input  logic [11:0] write_address,
  input  logic [1:0]  write_bank,
  output logic [2:0]  sdram_command,
  output logic [11:0] sdram_address,
  output logic [1:0]  sdram_bank,
  output logic        refresh_overrun
);

  // Command encodings {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP          = 3'b111;
  localparam logic [2:0] CMD_PRECHARGE    = 3'b010;
  localparam logic [2:0] CMD_AUTO_REFRESH = 3'b001;

  localparam int CW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(REFRESH_INTERVAL - 1);
  // Delay counters are 4 bits: T_RP and T_RFC must each be <= 15
  localparam logic [3:0] RP_DELAY  = 4'(T_RP);
  localparam logic [3:0] RFC_DELAY = 4'(T_RFC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT_READ,
    S_GRANT_WRITE,
    S_REF_DRAIN,
    S_REF_PRE,
    S_REF_CMD
  } state_t;

  typedef enum logic {
    LAST_READ,
    LAST_WRITE
  } grant_t;

  state_t          state_q, state_d;
  grant_t          last_grant_q, last_grant_d;
  logic            seen_busy_q, seen_busy_d;
  logic            refresh_pending_q, refresh_pending_d;
  logic            refresh_overrun_q, refresh_overrun_d;
  logic [CW-1:0]   refresh_cnt_q, refresh_cnt_d;
  logic [3:0]      delay_q, delay_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [11:0]     addr_q, addr_d;
  logic [1:0]      bank_q, bank_d;
  logic            refresh_expire;
  logic            pending_clr;

  always_comb begin
    refresh_expire    = (refresh_cnt_q == '0);
    refresh_cnt_d     = refresh_expire ? CNT_RELOAD : refresh_cnt_q - 1'b1;
    refresh_overrun_d = refresh_overrun_q | (refresh_expire & refresh_pending_q);
    // A new expiry outranks the clear issued at the end of the previous refresh
    refresh_pending_d = refresh_expire | (refresh_pending_q & ~pending_clr);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    seen_busy_d  = seen_busy_q;
    delay_d      = delay_q;
    cmd_d        = CMD_NOP;
    addr_d       = '0;
    bank_d       = '0;
    pending_clr  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        seen_busy_d = 1'b0;
        if (refresh_pending_q) begin
          state_d = S_REF_DRAIN;
        end else if (read_req && write_req) begin
          state_d = (last_grant_q == LAST_WRITE) ? S_GRANT_READ : S_GRANT_WRITE;
        end else if (read_req) begin
          state_d = S_GRANT_READ;
        end else if (write_req) begin
          state_d = S_GRANT_WRITE;
        end
      end

      S_GRANT_READ: begin
        seen_busy_d = seen_busy_q | ~read_idle;
        if (read_idle && (seen_busy_q || !read_req) &&
            (!read_req || write_req || refresh_pending_q)) begin
          state_d      = S_IDLE;
          last_grant_d = LAST_READ;
        end
      end

      S_GRANT_WRITE: begin
        seen_busy_d = seen_busy_q | ~write_idle;
        if (write_idle && (seen_busy_q || !write_req) &&
            (!write_req || read_req || refresh_pending_q)) begin
          state_d      = S_IDLE;
          last_grant_d = LAST_WRITE;
        end
      end

      S_REF_DRAIN: begin
        if (read_idle && write_idle) begin
          state_d    = S_REF_PRE;
          cmd_d      = CMD_PRECHARGE;
          addr_d[10] = 1'b1;
          delay_d    = RP_DELAY;
        end
      end

      S_REF_PRE: begin
        if (delay_q == '0) begin
          state_d = S_REF_CMD;
          cmd_d   = CMD_AUTO_REFRESH;
          delay_d = RFC_DELAY;
        end else begin
          delay_d = delay_q - 1'b1;
        end
      end

      S_REF_CMD: begin
        if (delay_q == '0) begin
          state_d     = S_IDLE;
          pending_clr = 1'b1;
        end else begin
          delay_d = delay_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      last_grant_q      <= LAST_WRITE;
      seen_busy_q       <= 1'b0;
      refresh_pending_q <= 1'b0;
      refresh_overrun_q <= 1'b0;
      refresh_cnt_q     <= CNT_RELOAD;
      delay_q           <= '0;
      cmd_q             <= CMD_NOP;
      addr_q            <= '0;
      bank_q            <= '0;
    end else begin
      state_q           <= state_d;
      last_grant_q      <= last_grant_d;
      seen_busy_q       <= seen_busy_d;
      refresh_pending_q <= refresh_pending_d;
      refresh_overrun_q <= refresh_overrun_d;
      refresh_cnt_q     <= refresh_cnt_d;
      delay_q           <= delay_d;
      cmd_q             <= cmd_d;
      addr_q            <= addr_d;
      bank_q            <= bank_d;
    end
  end

  always_comb begin
    read_enable     = (state_q == S_GRANT_READ);
    write_enable    = (state_q == S_GRANT_WRITE);
    auto_refresh    = refresh_pending_q || (state_q == S_REF_DRAIN) ||
                      (state_q == S_REF_PRE) || (state_q == S_REF_CMD);
    refresh_overrun = refresh_overrun_q;
  end

  always_comb begin
    sdram_command = cmd_q;
    sdram_address = addr_q;
    sdram_bank    = bank_q;
    if (state_q == S_GRANT_READ) begin
      sdram_command = read_command;
      sdram_address = read_address;
      sdram_bank    = read_bank;
    end else if (state_q == S_GRANT_WRITE) begin
      sdram_command = write_command;
      sdram_address = write_address;
      sdram_bank    = write_bank;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// Directed bench for sdram_cmd_scheduler with a short refresh interval.
module tb_sdram_cmd_scheduler;

  localparam logic [2:0] NOP = 3'b111;
  localparam logic [2:0] PRE = 3'b010;
  localparam logic [2:0] AR  = 3'b001;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_req, write_req;
  logic        read_enable, write_enable;
  logic        read_idle, write_idle;
  logic        auto_refresh;
  logic [2:0]  read_command, write_command;
  logic [11:0] read_address, write_address;
  logic [1:0]  read_bank, write_bank;
  logic [2:0]  sdram_command;
  logic [11:0] sdram_address;
  logic [1:0]  sdram_bank;
  logic        refresh_overrun;

  int total = 0;
  int bad   = 0;

  sdram_cmd_scheduler #(.REFRESH_INTERVAL(20), .T_RP(2), .T_RFC(7)) dut (
    .clk(clk), .rst(rst),
    .read_req(read_req), .write_req(write_req),
    .read_enable(read_enable), .write_enable(write_enable),
    .read_idle(read_idle), .write_idle(write_idle),
    .auto_refresh(auto_refresh),
    .read_command(read_command), .read_address(read_address), .read_bank(read_bank),
    .write_command(write_command), .write_address(write_address), .write_bank(write_bank),
    .sdram_command(sdram_command), .sdram_address(sdram_address), .sdram_bank(sdram_bank),
    .refresh_overrun(refresh_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Ticks until auto_refresh rises; returns 41 if it never does
  task automatic wait_refresh(output int n);
    n = 41;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (auto_refresh) begin
        n = i;
        break;
      end
    end
  endtask

  int n, cnt_a, cnt_b;

  initial begin
    rst = 1'b1;
    read_req = 1'b1; write_req = 1'b0;
    read_idle = 1'b1; write_idle = 1'b1;
    read_command = 3'b011; read_address = 12'h155; read_bank = 2'd2;
    write_command = 3'b100; write_address = 12'h2AA; write_bank = 2'd1;

    // Test 1: single read requester
    reset_dut();
    check("rst_ren", 16'(read_enable), 16'd0);
    check("rst_wen", 16'(write_enable), 16'd0);
    check("rst_aref", 16'(auto_refresh), 16'd0);
    check("rst_ovr", 16'(refresh_overrun), 16'd0);
    check("rst_cmd", 16'(sdram_command), 16'(NOP));
    check("rst_addr", 16'(sdram_address), 16'd0);
    check("rst_bank", 16'(sdram_bank), 16'd0);
    cnt_a = 0;
    tick();
    check("t1_ren", 16'(read_enable), 16'd1);
    check("t1_cmd", 16'(sdram_command), 16'(3'b011));
    check("t1_addr", 16'(sdram_address), 16'h155);
    check("t1_bank", 16'(sdram_bank), 16'd2);
    read_idle = 1'b0;
    tick(); cnt_a += int'(write_enable);
    read_idle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); cnt_a += int'(write_enable);
    end
    check("t1_ren_held", 16'(read_enable), 16'd1);
    check("t1_wen_cycles", 16'(cnt_a), 16'd0);
    read_command = 3'b101; read_address = 12'h0F0;
    #1;
    check("t1_cmd_comb", 16'(sdram_command), 16'(3'b101));
    check("t1_addr_comb", 16'(sdram_address), 16'h0F0);

    // Test 2: both requesting -> R,W,R,W
    write_req = 1'b1;
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t2_ren_%0d", k), 16'(read_enable), 16'((k % 2) == 0));
      check($sformatf("t2_wen_%0d", k), 16'(write_enable), 16'((k % 2) == 1));
      if (k == 1) check("t2_wcmd", 16'(sdram_command), 16'(3'b100));
      if (k == 1) check("t2_wbank", 16'(sdram_bank), 16'd1);
      if ((k % 2) == 0) read_idle = 1'b0; else write_idle = 1'b0;
      tick();
      read_idle = 1'b1; write_idle = 1'b1;
      tick();
      check($sformatf("t2_off_%0d", k), 16'({read_enable, write_enable}), 16'd0);
    end

    // Test 3: refresh sequence with no requests
    read_req = 1'b0; write_req = 1'b0;
    reset_dut();
    wait_refresh(n);
    check("t3_latency", 16'(n), 16'd20);
    check("t3_cmd_p", 16'(sdram_command), 16'(NOP));
    tick();
    check("t3_drain_cmd", 16'(sdram_command), 16'(NOP));
    tick();
    check("t3_pre_cmd", 16'(sdram_command), 16'(PRE));
    check("t3_pre_addr", 16'(sdram_address), 16'h400);
    check("t3_pre_aref", 16'(auto_refresh), 16'd1);
    cnt_a = 0;
    for (int i = 0; i < 2; i++) begin
      tick(); cnt_a += int'(sdram_command == NOP);
    end
    check("t3_rp_nops", 16'(cnt_a), 16'd2);
    tick();
    check("t3_ar_cmd", 16'(sdram_command), 16'(AR));
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      cnt_a += int'(sdram_command == NOP);
      cnt_b += int'(auto_refresh);
    end
    check("t3_rfc_nops", 16'(cnt_a), 16'd7);
    check("t3_rfc_aref", 16'(cnt_b), 16'd7);
    tick();
    check("t3_done_aref", 16'(auto_refresh), 16'd0);
    check("t3_done_cmd", 16'(sdram_command), 16'(NOP));

    // Test 4: refresh expires mid read
    read_req = 1'b1;
    reset_dut();
    tick();
    check("t4_ren", 16'(read_enable), 16'd1);
    read_idle = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 23; i++) begin
      tick();
      cnt_a += int'(!read_enable || sdram_command == PRE);
    end
    check("t4_held", 16'(cnt_a), 16'd0);
    check("t4_aref", 16'(auto_refresh), 16'd1);
    read_idle = 1'b1; read_req = 1'b0;
    tick();
    check("t4_exit_ren", 16'(read_enable), 16'd0);
    check("t4_exit_cmd", 16'(sdram_command), 16'(NOP));
    tick();
    check("t4_drain_cmd", 16'(sdram_command), 16'(NOP));
    tick();
    check("t4_pre", 16'(sdram_command), 16'(PRE));
    check("t4_pre_en", 16'({read_enable, write_enable}), 16'd0);

    // Test 5: long drain -> sticky overrun, single refresh
    write_idle = 1'b0;
    reset_dut();
    cnt_a = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      cnt_a += int'(sdram_command != NOP || read_enable || write_enable);
    end
    check("t5_no_cmd", 16'(cnt_a), 16'd0);
    check("t5_ovr", 16'(refresh_overrun), 16'd1);
    check("t5_aref", 16'(auto_refresh), 16'd1);
    write_idle = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      cnt_a += int'(sdram_command == PRE);
      cnt_b += int'(sdram_command == AR);
    end
    check("t5_pre_count", 16'(cnt_a), 16'd1);
    check("t5_ar_count", 16'(cnt_b), 16'd1);
    check("t5_done_aref", 16'(auto_refresh), 16'd0);
    check("t5_ovr_sticky", 16'(refresh_overrun), 16'd1);

    // Test 6: reset during the AUTO REFRESH wait
    reset_dut();
    check("t6_ovr_clr", 16'(refresh_overrun), 16'd0);
    wait_refresh(n);
    check("t6_latency1", 16'(n), 16'd20);
    for (int i = 0; i < 5; i++) tick();
    check("t6_in_rfc", 16'(sdram_command), 16'(AR));
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    check("t6_rst_cmd", 16'(sdram_command), 16'(NOP));
    check("t6_rst_aref", 16'(auto_refresh), 16'd0);
    rst = 1'b0;
    wait_refresh(n);
    check("t6_latency2", 16'(n), 16'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
